// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment display driver with leading-zero blanking
// Ports: clk/reset (sync, active-high); wr_en/wr_addr/wr_data/wr_dp write the digit file;
// dec_mode renders 0xA..0xF as '-'; blank_lz suppresses leading zeros;
// seg_out (bit0=a..bit6=g), dp_out, digit_en (one-hot) drive the display;
// frame_tick pulses once per full scan.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 1024,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic wr_dp,
  input  logic dec_mode,
  input  logic blank_lz,
  output logic [6:0] seg_out,
  output logic dp_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic frame_tick
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic INV = ACTIVE_LOW != 0;
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [NUM_DIGITS-1:0][3:0] digit;
  logic [NUM_DIGITS-1:0] dp;
  logic [CW-1:0] count;
  logic [AW-1:0] index;
  logic [3:0] cur;
  logic nz_above;
  logic lz_blank;
  logic active;
  logic slot_end;
  logic last_digit;
  logic [6:0] glyph;
  logic [NUM_DIGITS-1:0] en_next;
  always_comb begin
    cur = digit[index];
    nz_above = 1'b0;
    // any nonzero digit at or above the scanned position means it is not a leading zero
    for (int j = 0; j < NUM_DIGITS; j++)
      nz_above = nz_above | (j >= int'(index) && digit[j] != 4'h0);
    lz_blank = blank_lz && index != '0 && !nz_above;
    glyph = lz_blank ? 7'h00 : (dec_mode && cur > 4'd9) ? 7'h40 : FONT[cur];
    active = int'(count) >= BLANK_CYCLES;
    en_next = active ? NUM_DIGITS'(1) << index : '0;
    slot_end = count == CW'(PRESCALE - 1);
    last_digit = index == AW'(NUM_DIGITS - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
      dp <= '0;
      count <= '0;
      index <= '0;
      seg_out <= {7{INV}};
      dp_out <= INV;
      digit_en <= {NUM_DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      count <= slot_end ? '0 : count + 1'b1;
      index <= slot_end ? (last_digit ? '0 : index + 1'b1) : index;
      frame_tick <= slot_end && last_digit;
      seg_out <= (active ? glyph : 7'h00) ^ {7{INV}};
      dp_out <= (active && dp[index]) ^ INV;
      digit_en <= en_next ^ {NUM_DIGITS{INV}};
      if (wr_en && int'(wr_addr) < NUM_DIGITS) begin
        digit[wr_addr] <= wr_data;
        dp[wr_addr] <= wr_dp;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, font, blanking, writes, polarity and reset
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [1:0] addr_a = '0;
  logic [2:0] addr_b = '0;
  logic [3:0] wr_data = '0;
  logic wr_dp = 1'b0, dec_mode = 1'b0, blank_lz = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic dp_a, dp_b, ft_a, ft_b;
  logic [3:0] en_a;
  logic [4:0] en_b;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] exp_en [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2};
  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(wr_data),
    .wr_dp(wr_dp), .dec_mode(dec_mode), .blank_lz(blank_lz), .seg_out(seg_a),
    .dp_out(dp_a), .digit_en(en_a), .frame_tick(ft_a));
  seg7_scan_driver #(.NUM_DIGITS(5), .PRESCALE(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(wr_data),
    .wr_dp(wr_dp), .dec_mode(dec_mode), .blank_lz(blank_lz), .seg_out(seg_b),
    .dp_out(dp_b), .digit_en(en_b), .frame_tick(ft_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_a(input logic [1:0] a, input logic [3:0] d, input logic p);
    addr_a = a; wr_data = d; wr_dp = p; wr_en_a = 1'b1;
    tick;
    wr_en_a = 1'b0;
  endtask
  task automatic wr_b(input logic [2:0] a, input logic [3:0] d, input logic p);
    addr_b = a; wr_data = d; wr_dp = p; wr_en_b = 1'b1;
    tick;
    wr_en_b = 1'b0;
  endtask
  task automatic wait_a(input int d);
    int i;
    for (i = 0; i < 40; i++) begin
      tick;
      if (en_a == 4'(1 << d)) break;
    end
    chk($sformatf("wait_a%0d", d), 32'(i < 40), 1);
  endtask
  task automatic wait_b(input int d);
    int i;
    for (i = 0; i < 40; i++) begin
      tick;
      if (en_b == ~5'(1 << d)) break;
    end
    chk($sformatf("wait_b%0d", d), 32'(i < 40), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) tick;
    chk("rst_seg_a", seg_a, 7'h00);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_en_a", en_a, 4'h0);
    chk("rst_ft_a", ft_a, 0);
    chk("rst_seg_b", seg_b, 7'h7F);
    chk("rst_dp_b", dp_b, 1);
    chk("rst_en_b", en_b, 5'h1F);
    chk("rst_ft_b", ft_b, 0);
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (k <= 8) chk($sformatf("scan_en_k%0d", k), en_a, exp_en[k-1]);
      chk($sformatf("frame_tick_k%0d", k), ft_a, 32'(k % 16 == 0));
    end
    wr_a(2'd3, 4'hF, 1'b0);
    wr_a(2'd2, 4'h0, 1'b0);
    wr_a(2'd1, 4'h9, 1'b0);
    wr_a(2'd0, 4'hA, 1'b0);
    wait_a(0); chk("hex_d0", seg_a, 7'h77);
    wait_a(1); chk("hex_d1", seg_a, 7'h6F);
    wait_a(2); chk("hex_d2", seg_a, 7'h3F);
    wait_a(3); chk("hex_d3", seg_a, 7'h71);
    chk("hex_dp3", dp_a, 0);
    dec_mode = 1'b1;
    wait_a(0); chk("dec_d0", seg_a, 7'h40);
    wait_a(3); chk("dec_d3", seg_a, 7'h40);
    wait_a(1); chk("dec_d1", seg_a, 7'h6F);
    dec_mode = 1'b0;
    wr_a(2'd3, 4'h0, 1'b1);
    wr_a(2'd2, 4'h0, 1'b0);
    wr_a(2'd1, 4'h4, 1'b0);
    wr_a(2'd0, 4'h0, 1'b0);
    blank_lz = 1'b1;
    wait_a(3); chk("lz_d3", seg_a, 7'h00); chk("lz_dp3", dp_a, 1);
    wait_a(0); chk("lz_d0", seg_a, 7'h3F);
    wait_a(1); chk("lz_d1", seg_a, 7'h66);
    wait_a(2); chk("lz_d2", seg_a, 7'h00);
    blank_lz = 1'b0;
    wait_a(3); chk("nolz_d3", seg_a, 7'h3F); chk("nolz_dp3", dp_a, 1);
    wait_a(2); chk("nolz_d2", seg_a, 7'h3F);
    wait_a(0);
    wait_a(1); chk("mid_before", seg_a, 7'h66);
    addr_a = 2'd1; wr_data = 4'h7; wr_dp = 1'b0; wr_en_a = 1'b1;
    tick;
    wr_en_a = 1'b0;
    chk("mid_write_edge", seg_a, 7'h66);
    tick;
    chk("mid_after", seg_a, 7'h07);
    chk("mid_en", en_a, 4'h2);
    wr_b(3'd0, 4'h8, 1'b1);
    wr_b(3'd5, 4'h1, 1'b1);
    wr_b(3'd6, 4'h1, 1'b1);
    wr_b(3'd7, 4'h1, 1'b1);
    wait_b(0);
    chk("al_seg", seg_b, 7'h00);
    chk("al_dp", dp_b, 0);
    chk("al_en", en_b, 5'b11110);
    wait_b(1); chk("al_d1_seg", seg_b, 7'h40); chk("al_d1_dp", dp_b, 1);
    wait_b(4); chk("al_d4_seg", seg_b, 7'h40);
    wait_a(1);
    wait_a(2);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_seg_a", seg_a, 7'h00);
    chk("mrst_en_a", en_a, 4'h0);
    chk("mrst_dp_a", dp_a, 0);
    chk("mrst_seg_b", seg_b, 7'h7F);
    chk("mrst_en_b", en_b, 5'h1F);
    chk("mrst_dp_b", dp_b, 1);
    tick; chk("restart_k1", en_a, 4'h0);
    tick; chk("restart_k2", en_a, 4'h1);
    chk("restart_d0", seg_a, 7'h3F);
    wait_a(1); chk("clr_d1", seg_a, 7'h3F);
    wait_a(3); chk("clr_dp3", dp_a, 0);
    wait_b(0); chk("clr_b_seg", seg_b, 7'h40); chk("clr_b_dp", dp_b, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
